// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The multiply-latency default and statistics width live here so the top and bench agree.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    localparam int MUL_LAT_DEF = 32;
    localparam int STALL_W     = 16;
    localparam int MCNT_W      = 6;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in ID/EX writes.
// Purely combinational; register 0 never creates a dependency.
module hazard_detect (
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    always_comb begin
        load_use = idex_memread && (idex_rt != 5'd0) &&
                   ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: redirect flushes, load-use bubbles and multi-cycle multiply stalls.
// Also keeps a saturating count of front-end stall cycles.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_uses_rt,
    input  logic               idex_memread,
    input  logic [4:0]         idex_rt,
    input  logic               ex_branch_taken,
    input  logic               ex_jump,
    input  logic               ex_mul,
    input  logic               stat_clr,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ifid_flush,
    output logic               idex_flush,
    output logic               idex_hold,
    output logic               exmem_bubble,
    output logic               mul_start,
    output logic               mul_done,
    output logic               mul_busy,
    output logic [STALL_W-1:0] stall_cnt,
    output state_t             dbg_state,
    output logic [MCNT_W-1:0]  dbg_mcnt
);

    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MUL_LAT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    state_t            state, state_nxt;
    logic [MCNT_W-1:0] mcnt, mcnt_nxt;
    logic              load_use;
    logic              redirect;

    hazard_detect u_hazard_detect (
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .load_use     (load_use)
    );

    assign redirect = ex_branch_taken | ex_jump;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            mcnt  <= '0;
        end else begin
            state <= state_nxt;
            mcnt  <= mcnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        mcnt_nxt     = mcnt;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        mul_start    = 1'b0;
        mul_done     = 1'b0;
        mul_busy     = 1'b0;
        case (state)
            ST_RUN: begin
                // Redirect outranks a multiply so a wrong-path multiply never starts.
                if (redirect) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ex_mul) begin
                    mul_start    = 1'b1;
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    state_nxt    = ST_MUL_WAIT;
                    mcnt_nxt     = MCNT_W'(1);
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                end
            end
            ST_MUL_WAIT: begin
                mul_busy = 1'b1;
                if (mcnt < MCNT_LAST) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    mcnt_nxt     = mcnt + MCNT_W'(1);
                end else begin
                    mul_done  = 1'b1;
                    state_nxt = ST_RUN;
                    mcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_RUN;
                mcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stat_clr) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != STALL_MAX)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    assign dbg_state = state;
    assign dbg_mcnt  = mcnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MUL_LAT=32.
// Expected values are hand-derived from the controller behaviour.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs, id_rt, idex_rt;
    logic        id_uses_rt, idex_memread;
    logic        ex_branch_taken, ex_jump, ex_mul, stat_clr;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, idex_hold;
    logic        exmem_bubble, mul_start, mul_done, mul_busy;
    logic [15:0] stall_cnt;
    state_t      dbg_state;
    logic [5:0]  dbg_mcnt;

    int n_vec = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rt      (id_uses_rt),
        .idex_memread    (idex_memread),
        .idex_rt         (idex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .ex_mul          (ex_mul),
        .stat_clr        (stat_clr),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .idex_hold       (idex_hold),
        .exmem_bubble    (exmem_bubble),
        .mul_start       (mul_start),
        .mul_done        (mul_done),
        .mul_busy        (mul_busy),
        .stall_cnt       (stall_cnt),
        .dbg_state       (dbg_state),
        .dbg_mcnt        (dbg_mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; idex_rt = 5'd0;
        id_uses_rt = 1'b0; idex_memread = 1'b0;
        ex_branch_taken = 1'b0; ex_jump = 1'b0; ex_mul = 1'b0; stat_clr = 1'b0;
    endtask

    initial begin
        int done_pulses;
        int waited;
        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_state", 32'(dbg_state), 32'(ST_RUN));
        chk("rst_mcnt", 32'(dbg_mcnt), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_pc_write", 32'(pc_write), 1);
        chk("rst_ifid_write", 32'(ifid_write), 1);
        chk("rst_mul_busy", 32'(mul_busy), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Load-use on rs
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        #1;
        chk("lu_pc_write", 32'(pc_write), 0);
        chk("lu_ifid_write", 32'(ifid_write), 0);
        chk("lu_idex_flush", 32'(idex_flush), 1);
        chk("lu_ifid_flush", 32'(ifid_flush), 0);
        tick();
        idle_inputs();
        #1;
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_release", 32'(pc_write), 1);

        // Register 0 never hazards
        idex_memread = 1'b1; idex_rt = 5'd0; id_rs = 5'd0;
        #1;
        chk("r0_pc_write", 32'(pc_write), 1);
        chk("r0_idex_flush", 32'(idex_flush), 0);
        tick();
        chk("r0_stall_cnt", 32'(stall_cnt), 1);

        // rt match only counts when the instruction reads rt
        idex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
        #1;
        chk("rt_unused_pc_write", 32'(pc_write), 1);
        id_uses_rt = 1'b1;
        #1;
        chk("rt_used_pc_write", 32'(pc_write), 0);
        tick();
        idle_inputs();
        #1;
        chk("rt_stall_cnt", 32'(stall_cnt), 2);

        // Redirect beats load-use; redirect beats a multiply
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8; ex_branch_taken = 1'b1;
        #1;
        chk("br_ifid_flush", 32'(ifid_flush), 1);
        chk("br_idex_flush", 32'(idex_flush), 1);
        chk("br_pc_write", 32'(pc_write), 1);
        ex_branch_taken = 1'b0; ex_jump = 1'b1; ex_mul = 1'b1;
        #1;
        chk("jmp_mul_start", 32'(mul_start), 0);
        chk("jmp_exmem_bubble", 32'(exmem_bubble), 0);
        chk("jmp_pc_write", 32'(pc_write), 1);
        tick();
        idle_inputs();
        #1;
        chk("br_stall_cnt", 32'(stall_cnt), 2);
        chk("br_state", 32'(dbg_state), 32'(ST_RUN));

        // Full multiply: start in cycle 0, done in cycle 31
        ex_mul = 1'b1;
        #1;
        chk("mul_start", 32'(mul_start), 1);
        chk("mul_c0_pc_write", 32'(pc_write), 0);
        chk("mul_c0_idex_hold", 32'(idex_hold), 1);
        chk("mul_c0_exmem_bubble", 32'(exmem_bubble), 1);
        chk("mul_c0_busy", 32'(mul_busy), 0);
        tick();
        ex_mul = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            if (c == 5) begin
                idex_memread = 1'b1; idex_rt = 5'd4; id_rs = 5'd4;
                ex_branch_taken = 1'b1; ex_mul = 1'b1;
            end
            #1;
            chk($sformatf("mul_c%0d_busy", c), 32'(mul_busy), 1);
            chk($sformatf("mul_c%0d_start", c), 32'(mul_start), 0);
            if (c < 31) begin
                chk($sformatf("mul_c%0d_pc_write", c), 32'(pc_write), 0);
                chk($sformatf("mul_c%0d_done", c), 32'(mul_done), 0);
            end else begin
                chk("mul_c31_done", 32'(mul_done), 1);
                chk("mul_c31_pc_write", 32'(pc_write), 1);
                chk("mul_c31_idex_hold", 32'(idex_hold), 0);
            end
            if (c == 5) begin
                chk("mul_ignore_flush", 32'(ifid_flush), 0);
                idle_inputs();
            end
            tick();
        end
        chk("mul_end_busy", 32'(mul_busy), 0);
        chk("mul_end_state", 32'(dbg_state), 32'(ST_RUN));
        chk("mul_stall_cnt", 32'(stall_cnt), 33);

        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        #1;
        chk("clr_stall_cnt", 32'(stall_cnt), 0);

        // Asynchronous reset in the middle of a multiply
        ex_mul = 1'b1;
        tick();
        ex_mul = 1'b0;
        waited = 0;
        while (dbg_mcnt != 6'd10 && waited < 40) begin
            tick();
            waited++;
        end
        chk("abort_reach_mcnt10", 32'(dbg_mcnt), 10);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_state", 32'(dbg_state), 32'(ST_RUN));
        chk("abort_mcnt", 32'(dbg_mcnt), 0);
        chk("abort_busy", 32'(mul_busy), 0);
        chk("abort_pc_write", 32'(pc_write), 1);
        chk("abort_stall_cnt", 32'(stall_cnt), 0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        done_pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (mul_done) done_pulses++;
        end
        chk("abort_no_done", 32'(done_pulses), 0);

        // Saturation: hold a load-use stall for 65535 cycles
        idex_memread = 1'b1; idex_rt = 5'd8; id_rs = 5'd8;
        repeat (65535) @(posedge clk);
        #1;
        chk("sat_reach", 32'(stall_cnt), 32'h0000_FFFF);
        tick();
        chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
        stat_clr = 1'b1;
        tick();
        chk("sat_clr_over_inc", 32'(stall_cnt), 0);
        stat_clr = 1'b0;
        tick();
        chk("sat_restart", 32'(stall_cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MUL_LAT, default 32, EX-stage occupancy in cycles of one multiply; legal range 2..64.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID.
REQ-005 id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne).
REQ-006 idex_memread, idex_rt  in  1, 5  MemRead and rt of the instruction in ID/EX.
REQ-007 ex_branch_taken, ex_jump  in  1 each  redirect resolved in EX.
REQ-008 ex_mul  in  1  the instruction in EX is a multiply.
REQ-009 stat_clr  in  1  synchronous clear of stall_cnt.
REQ-010 pc_write, ifid_write  out  1 each  PC and IF/ID enables.
REQ-011 ifid_flush, idex_flush  out  1 each  squash IF/ID; force zero controls into ID/EX.
REQ-012 idex_hold  out  1  ID/EX keeps its contents.
REQ-013 exmem_bubble  out  1  zero controls into EX/MEM.
REQ-014 mul_start, mul_done  out  1 each  one-cycle multiplier start/finish pulses.
REQ-015 mul_busy  out  1  state is MUL_WAIT.
REQ-016 stall_cnt  out  16  saturating count of cycles with pc_write=0.

Function
REQ-017 States: RUN, MUL_WAIT; 6-bit cycle counter mcnt.
REQ-018 Outputs are combinational from state, mcnt and current inputs; defaults pc_write=ifid_write=1, all others 0.
REQ-019 load_use = idex_memread & (idex_rt!=0) & ((idex_rt==id_rs) | (id_uses_rt & idex_rt==id_rt)).
REQ-020 RUN priority 1, redirect (ex_branch_taken|ex_jump): ifid_flush=1, idex_flush=1, pc_write=1; stay RUN.
REQ-021 RUN priority 2, ex_mul: mul_start=1, pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1; next MUL_WAIT, mcnt<=1.
REQ-022 RUN priority 3, load_use: pc_write=0, ifid_write=0, idex_flush=1 (one bubble); stay RUN.
REQ-023 MUL_WAIT with mcnt<MUL_LAT-1: same stall outputs as REQ-021 except mul_start=0; mcnt increments.
REQ-024 MUL_WAIT with mcnt==MUL_LAT-1: mul_done=1, stall released (default outputs), next RUN, mcnt<=0.
REQ-025 Multiply latency: EX occupancy exactly MUL_LAT cycles, front-end stall MUL_LAT-1 cycles.
REQ-026 Redirect, load_use and ex_mul are ignored in MUL_WAIT.
REQ-027 ex_mul together with a redirect is illegal; redirect wins and mul_start stays 0.
REQ-028 stall_cnt increments each cycle pc_write=0 and saturates at 16'hFFFF.
REQ-029 stat_clr loads 0, overriding any increment in the same cycle.

Reset
REQ-030 rst asserted: state=RUN, mcnt=0, stall_cnt=0 immediately, regardless of clk.
REQ-031 Outputs while rst asserted and after release follow RUN decode.
REQ-032 rst during MUL_WAIT aborts the multiply with no mul_done pulse.

Structure
REQ-033 Package pipe_ctrl_pkg holds the state enum, MUL_LAT default and the stall_cnt width.
REQ-034 The load_use comparator is sub-module hazard_detect (combinational, no state).
REQ-035 FSM, mcnt and stall_cnt stay in the top module.

Verification
REQ-036 idex_memread=1, idex_rt=8, id_rs=8 in RUN -> one cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1.
REQ-037 idex_rt=0, id_rs=0, idex_memread=1 -> no stall; id_uses_rt=0, id_rt=idex_rt=9 -> no stall.
REQ-038 ex_mul=1 with MUL_LAT=32 -> mul_start in cycle 0, mul_busy cycles 1..31, mul_done in cycle 31, stall_cnt=31.
REQ-039 load_use together with ex_branch_taken -> flushes asserted, pc_write=1, no stall.
REQ-040 rst asserted at mcnt=10 -> state RUN, mcnt=0 asynchronously; no mul_done pulse.
REQ-041 Preload stall_cnt to 16'hFFFF, apply stall -> holds 16'hFFFF; stat_clr with stall -> 0.
